ps2_host_rx: RTL



---
 rtl/ps2_host_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_rx.sv
// ps2_host_rx - host-side PS/2 frame receiver.
//
// Samples the asynchronous ps2_clk/ps2_data pair in the clk domain, debounces
// the clock, decodes 11-bit frames (start, 8 data bits LSB first, odd parity,
// stop) and queues good bytes for a valid/read consumer.
//
// Build option: define PS2_HOST_RX_FIFO_EN for a 2**FIFO_BITS-entry FIFO;
// otherwise a single holding register is used and FIFO_BITS is ignored.
//
// Ports:
//   clk, reset_n       core clock, asynchronous active-low reset
//   ps2_clk, ps2_data  raw PS/2 lines (asynchronous, idle high)
//   rx_data, rx_valid  head byte and non-empty flag
//   rx_read            pop the head (ignored while rx_valid=0)
//   parity_err         1-cycle pulse: frame dropped for bad parity
//   frame_err          1-cycle pulse: bad start/stop bit or timeout
//   overflow           1-cycle pulse: good byte dropped, storage full
//   busy               frame in progress
module ps2_host_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16384,
  parameter int unsigned FIFO_BITS      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          strobe;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          push;
  logic [7:0]    push_data;

  // Synchronizers and clock filter. The filtered clock flips only after
  // FILTER_LEN consecutive samples disagree with it; a 1->0 flip is the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= 1'b1;
      fcnt   <= '0;
      strobe <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      strobe <= 1'b0;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FILT_MAX) begin
        filt   <= clk_s2;
        fcnt   <= '0;
        strobe <= ~clk_s2;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Frame decoder
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      push       <= 1'b0;
      push_data  <= '0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      push       <= 1'b0;

      if (state == IDLE || strobe) tcnt <= '0;
      else                         tcnt <= tcnt + 1'b1;

      unique case (state)
        IDLE: if (strobe) begin
          if (!dat_s2) begin
            state  <= DATA;
            bitcnt <= '0;
          end else begin
            frame_err <= 1'b1;
          end
        end
        DATA: if (strobe) begin
          shreg  <= {dat_s2, shreg[7:1]};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == 3'd7) state <= PARITY;
        end
        PARITY: if (strobe) begin
          par_bit <= dat_s2;
          state   <= STOP;
        end
        STOP: if (strobe) begin
          state      <= IDLE;
          frame_err  <= ~dat_s2;
          parity_err <= ~(^{shreg, par_bit});
          push       <= dat_s2 & (^{shreg, par_bit});
          push_data  <= shreg;
        end
        default: state <= IDLE;
      endcase

      // Timeout overrides whatever the case above decided for this cycle.
      if (state != IDLE && !strobe && tcnt == TO_MAX) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        shreg     <= '0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef PS2_HOST_RX_FIFO_EN
  localparam int unsigned DEPTH = 2 ** FIFO_BITS;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_BITS:0] wptr, rptr;
  logic               empty, full, pop, do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                   (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
  assign pop     = rx_read & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_BITS-1:0]] <= push_data;
  end

  assign rx_valid = ~empty;
  assign rx_data  = empty ? '0 : mem[rptr[FIFO_BITS-1:0]];
`else
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       pop;
  logic       unused_fifo_bits;

  assign unused_fifo_bits = (FIFO_BITS != 0);
  assign pop = rx_read & hold_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (push) begin
        if (!hold_valid || pop) begin
          hold_data  <= push_data;
          hold_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign rx_valid = hold_valid;
  assign rx_data  = hold_data;
`endif

endmodule
